// File: rtl/zfloat_pkg.sv
// rtl/zfloat_pkg.sv - shared float widths, zero exponent and converter state encoding
package zfloat_pkg;
   localparam int ZF_EXP_W = 7;
   localparam int ZF_MAN_W = 15;
   localparam logic [ZF_EXP_W-1:0] ZF_ZERO_EXP = 7'h40;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      NORM,
      DONE
   } zf_state_e;
endpackage

// File: rtl/bcd_mac15.sv
// rtl/bcd_mac15.sv - one decimal step: acc*10 + digit, flagging digits above 9
module bcd_mac15
   import zfloat_pkg::*;
(
   input  logic [ZF_MAN_W-1:0] acc_i,
   input  logic [3:0]          digit_i,
   output logic [ZF_MAN_W-1:0] acc_o,
   output logic                bad_o
);
   // Accumulator never exceeds 9999, so the 15-bit sum cannot wrap.
   assign acc_o = (acc_i << 3) + (acc_i << 1) + {{(ZF_MAN_W-4){1'b0}}, digit_i};
   assign bad_o = (digit_i > 4'd9);
endmodule

// File: rtl/bcd_to_zfloat.sv
// rtl/bcd_to_zfloat.sv - signed packed-BCD integer to normalised float, one digit then one shift per cycle
module bcd_to_zfloat
   import zfloat_pkg::*;
#(
   parameter int NDIGITS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   sign_in,
   input  logic [4*NDIGITS-1:0]   bcd_in,
   output logic                   ready,
   output logic                   out_valid,
   output logic                   out_s,
   output logic [ZF_EXP_W-1:0]    out_e,
   output logic [ZF_MAN_W-1:0]    out_m,
   output logic                   out_zero,
   output logic                   out_err
);
   localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   zf_state_e            state_q, state_d;
   logic [ZF_MAN_W-1:0]  acc_q, acc_d;
   logic [DW-1:0]        dcnt_q, dcnt_d;
   logic [ZF_EXP_W-1:0]  ecnt_q, ecnt_d;
   logic                 sgn_q, sgn_d;
   logic [4*NDIGITS-1:0] bcd_q, bcd_d;
   logic                 out_s_q, out_s_d;
   logic [ZF_EXP_W-1:0]  out_e_q, out_e_d;
   logic [ZF_MAN_W-1:0]  out_m_q, out_m_d;
   logic                 out_zero_q, out_zero_d;
   logic                 out_err_q, out_err_d;

   logic [3:0]           digit;
   logic [ZF_MAN_W-1:0]  mac_acc;
   logic                 mac_bad;

   assign digit = bcd_q[dcnt_q*4 +: 4];

   bcd_mac15 u_mac (
      .acc_i   (acc_q),
      .digit_i (digit),
      .acc_o   (mac_acc),
      .bad_o   (mac_bad)
   );

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      dcnt_d     = dcnt_q;
      ecnt_d     = ecnt_q;
      sgn_d      = sgn_q;
      bcd_d      = bcd_q;
      out_s_d    = out_s_q;
      out_e_d    = out_e_q;
      out_m_d    = out_m_q;
      out_zero_d = out_zero_q;
      out_err_d  = out_err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sgn_d      = sign_in;
               bcd_d      = bcd_in;
               acc_d      = '0;
               dcnt_d     = DW'(NDIGITS - 1);
               ecnt_d     = 7'd14;
               out_zero_d = 1'b0;
               out_err_d  = 1'b0;
               state_d    = CONV;
            end
         end
         CONV: begin
            if (mac_bad) begin
               out_err_d  = 1'b1;
               out_zero_d = 1'b0;
               out_m_d    = '0;
               out_e_d    = ZF_ZERO_EXP;
               out_s_d    = sgn_q;
               state_d    = DONE;
            end else begin
               acc_d  = mac_acc;
               dcnt_d = dcnt_q - 1'b1;
               if (dcnt_q == '0) state_d = NORM;
            end
         end
         NORM: begin
            if (acc_q == '0) begin
               out_zero_d = 1'b1;
               out_m_d    = '0;
               out_e_d    = ZF_ZERO_EXP;
               out_s_d    = sgn_q;
               state_d    = DONE;
            end else if (acc_q[ZF_MAN_W-1]) begin
               out_m_d = acc_q;
               out_e_d = ecnt_q;
               out_s_d = sgn_q;
               state_d = DONE;
            end else begin
               acc_d  = acc_q << 1;
               ecnt_d = ecnt_q - 7'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         dcnt_q     <= '0;
         ecnt_q     <= '0;
         sgn_q      <= 1'b0;
         bcd_q      <= '0;
         out_s_q    <= 1'b0;
         out_e_q    <= ZF_ZERO_EXP;
         out_m_q    <= '0;
         out_zero_q <= 1'b0;
         out_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         dcnt_q     <= dcnt_d;
         ecnt_q     <= ecnt_d;
         sgn_q      <= sgn_d;
         bcd_q      <= bcd_d;
         out_s_q    <= out_s_d;
         out_e_q    <= out_e_d;
         out_m_q    <= out_m_d;
         out_zero_q <= out_zero_d;
         out_err_q  <= out_err_d;
      end
   end

   assign ready     = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_s     = out_s_q;
   assign out_e     = out_e_q;
   assign out_m     = out_m_q;
   assign out_zero  = out_zero_q;
   assign out_err   = out_err_q;
endmodule

// File: tb/tb_bcd_to_zfloat.sv
// tb/tb_bcd_to_zfloat.sv - randomized and directed checks of bcd_to_zfloat against an arithmetic model
module tb_bcd_to_zfloat;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        sign_in;
   logic [15:0] bcd_in;
   logic        ready, out_valid, out_s, out_zero, out_err;
   logic [6:0]  out_e;
   logic [14:0] out_m;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   bcd_to_zfloat #(.NDIGITS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sign_in   (sign_in),
      .bcd_in    (bcd_in),
      .ready     (ready),
      .out_valid (out_valid),
      .out_s     (out_s),
      .out_e     (out_e),
      .out_m     (out_m),
      .out_zero  (out_zero),
      .out_err   (out_err)
   );

   typedef struct {
      bit err;
      bit zero;
      bit s;
      int m;
      int e;
      int lat;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Value as an integer, normalised so that m/2^14 lies in [1,2); latency counted in edges after the start edge.
   function automatic exp_t model(input logic [15:0] bcd, input bit sgn);
      exp_t r;
      int   n, p, d;
      r = '{default: 0};
      r.s = sgn;
      n = 0;
      for (int i = 3; i >= 0; i--) begin
         d = int'(bcd[i*4 +: 4]);
         if (d > 9) begin
            r.err = 1; r.m = 0; r.e = 64; r.lat = 4 - i;
            return r;
         end
         n = n * 10 + d;
      end
      if (n == 0) begin
         r.zero = 1; r.m = 0; r.e = 64; r.lat = 5;
         return r;
      end
      p = 0;
      while ((n >> (p + 1)) != 0) p++;
      r.m   = n << (14 - p);
      r.e   = p;
      r.lat = 4 + (14 - p) + 1;
      return r;
   endfunction

   task automatic run_op(input string tag, input logic [15:0] bcd, input bit sgn);
      exp_t x;
      int   cyc;
      bit   seen;
      x = model(bcd, sgn);
      @(negedge clk);
      chk({tag, ".ready_idle"}, ready, 1);
      start = 1'b1; bcd_in = bcd; sign_in = sgn;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; bcd_in = 16'($urandom); sign_in = 1'($urandom);
      chk({tag, ".ready_busy"}, ready, 0);
      cyc = 0; seen = 0;
      while (!seen && cyc < 60) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         seen = out_valid;
      end
      chk({tag, ".seen"}, seen, 1);
      chk({tag, ".latency"}, cyc, x.lat);
      chk({tag, ".err"}, out_err, x.err);
      chk({tag, ".zero"}, out_zero, x.zero);
      chk({tag, ".m"}, out_m, x.m);
      chk({tag, ".e"}, out_e, x.e);
      if (!x.err) chk({tag, ".s"}, out_s, x.s);
      @(negedge clk);
      chk({tag, ".pulse_end"}, out_valid, 0);
      chk({tag, ".m_held"}, out_m, x.m);
   endtask

   initial begin
      int          cnt, first;
      logic [15:0] b;
      reset = 1'b1; start = 1'b0; sign_in = 1'b0; bcd_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.ready", ready, 1);
      chk("rst.valid", out_valid, 0);
      chk("rst.s", out_s, 0);
      chk("rst.e", out_e, 7'h40);
      chk("rst.m", out_m, 0);
      chk("rst.zero", out_zero, 0);
      chk("rst.err", out_err, 0);
      reset = 1'b0;

      run_op("one",     16'h0001, 1'b0);
      run_op("max",     16'h9999, 1'b0);
      run_op("ten_neg", 16'h0010, 1'b1);
      run_op("negzero", 16'h0000, 1'b1);
      run_op("bad",     16'h12A4, 1'b0);
      run_op("after",   16'h0037, 1'b0);
      run_op("bad_top", 16'hF000, 1'b1);

      // A second start during NORM must be ignored.
      @(negedge clk);
      start = 1'b1; bcd_in = 16'h0001; sign_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cnt = 0; first = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 8) start = 1'b1;
         if (c == 8) bcd_in = 16'h9999;
         if (c == 9) start = 1'b0;
         if (out_valid) begin
            cnt++;
            if (first == 0) first = c;
            if (cnt == 1) begin
               chk("restart.m", out_m, 15'h4000);
               chk("restart.e", out_e, 0);
            end
         end
      end
      chk("restart.pulses", cnt, 1);
      chk("restart.latency", first, 19);
      chk("restart.ready", ready, 1);

      // Reset mid-NORM aborts with no pulse.
      @(negedge clk);
      start = 1'b1; bcd_in = 16'h0003; sign_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst.ready", ready, 1);
      chk("midrst.valid", out_valid, 0);
      chk("midrst.m", out_m, 0);
      chk("midrst.e", out_e, 7'h40);
      chk("midrst.s", out_s, 0);
      cnt = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("midrst.no_pulse", cnt, 0);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 4; i++) b[i*4 +: 4] = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) b = b & 16'h00FF;
         if ($urandom_range(0, 7) == 0) b = 16'h0000;
         if ($urandom_range(0, 5) == 0) b[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
         run_op("rand", b, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
